spi_packet_feeder: RTL and testbench
====================================

Name: spi_packet_feeder

Overview:
- Sits directly upstream of the 12 MHz SPI master in the bridge FPGA, in the 48 MHz domain.
- Assembles the incoming command byte stream into 8-byte KMBox packets, buffers whole packets in a small FIFO, and issues them one at a time to the SPI master's tx_data/tx_valid/tx_ready interface.
- Returns each 64-bit slave response alongside the transaction.

Parameters:
DEPTH, 4, packet FIFO depth in 64-bit entries; power of two, 2..16
GAP_CLKS, 24, minimum idle clocks between the master's rx_valid and the next tx_valid
TIMEOUT_CLKS, 4800, idle clocks after which a partial packet is discarded (100 us at 48 MHz)

Ports:
clk  in  1  48 MHz system clock
rst  in  1  synchronous reset, active high
in_data  in  8  command byte
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid && in_ready
flush  in  1  drop FIFO contents and any partial packet
spi_tx_data  out  64  to master tx_data
spi_tx_valid  out  1  to master tx_valid
spi_tx_ready  in  1  from master tx_ready
spi_rx_data  in  64  from master rx_data
spi_rx_valid  in  1  from master rx_valid
resp_data  out  64  response for the last completed packet
resp_valid  out  1  one-clock pulse with resp_data
fifo_level  out  $clog2(DEPTH)+1  packets queued, excluding the one in flight
busy  out  1  high from spi_tx_valid until the GAP state ends
frame_err  out  1  one-clock pulse when a partial packet is discarded

Behaviour:
- Reset values (rst=1 at a clk edge): all outputs 0, except in_ready=1. FIFO is empty, byte_cnt=0, state=IDLE.
- Assembly:
  - The first byte of a packet lands in bits [63:56]; the eighth byte lands in [7:0].
  - byte_cnt is 0..7.
  - On the eighth accepted byte, the packet is written to the FIFO on that same edge.
- in_ready = !(byte_cnt==7 && FIFO full). Bytes 1..7 are accepted while the FIFO is full; only the completing byte stalls.
- Timeout:
  - The counter resets on every accepted byte and while byte_cnt==0.
  - When it reaches TIMEOUT_CLKS with byte_cnt!=0, byte_cnt returns to 0, the partial data is discarded, and frame_err pulses.
- FIFO:
  - Registered pointers; write and read in the same cycle are allowed.
  - Level is unchanged on a simultaneous push and pop.
  - A push to a full FIFO cannot occur, because in_ready blocks it.
- State machine:
  - IDLE: if FIFO non-empty && spi_tx_ready → pop the head into an output register and go to ISSUE.
  - ISSUE: spi_tx_valid=1 for exactly one clock with spi_tx_data stable → WAIT_BUSY.
  - WAIT_BUSY: wait for spi_tx_ready==0 (the master's accept) → WAIT_DONE.
  - WAIT_DONE: on spi_rx_valid, register resp_data=spi_rx_data and pulse resp_valid on the next clock → GAP.
  - GAP: count GAP_CLKS clocks → IDLE.
- Latency: with an empty FIFO, the master idle and the machine in IDLE, spi_tx_valid rises 2 clocks after the edge that accepts the eighth byte.
- spi_tx_data holds its value from ISSUE until the next pop.
- A spi_rx_valid arriving outside WAIT_DONE is ignored.
- Flush:
  - Clears the FIFO, byte_cnt and the timeout counter in one clock.
  - A byte presented in the flush cycle is dropped.
  - It does not abort the in-flight packet: the current state sequence completes, and its response is still delivered.
- Reset mid-transfer: the state returns to IDLE. No new issue occurs until spi_tx_ready is seen high, so a master still finishing a transfer is never double-issued.
- All counters saturate or wrap only as stated; widths are sized from the parameters.

Optional Feature:
SPI_FEEDER_STATS_EN:
- When defined, adds two outputs, pkt_count[15:0] and drop_count[15:0], both reset to 0 and wrapping at 16 bits.
  - pkt_count increments on each ISSUE.
  - drop_count increments by 1 per timed-out partial packet, and by the discarded entry count (plus 1 if byte_cnt!=0) on flush.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Push bytes 01..08 back-to-back, master model idle → spi_tx_data=0x0102030405060708 and spi_tx_valid high exactly 1 clock, 2 clocks after the 8th byte; response 0xA5A5...A5 appears on resp_data with a one-clock resp_valid.
- Push 5 packets (40 bytes) while the master holds spi_tx_ready=0 → first 4 packets queued; in_ready low only on the 40th byte; fifo_level=4; all 5 issue in order once ready rises, with at least 24 clocks from each rx_valid to the next tx_valid.
- Push 3 bytes, then idle 4800 clocks → frame_err single pulse; the next 8 bytes form a clean packet; drop_count=1 with SPI_FEEDER_STATS_EN.
- Queue 3 packets, assert flush during WAIT_DONE of the first → in-flight response still delivered; fifo_level=0; no further tx_valid.
- Assert rst for 1 clock mid-WAIT_DONE while the master keeps tx_ready=0 for 200 more clocks → outputs at reset values; no tx_valid until tx_ready=1 and a new packet has arrived.
- Simultaneous eighth-byte push and IDLE pop with fifo_level=1 → fifo_level stays 1; order preserved.

Source files
------------

// File: rtl/spi_packet_feeder.sv
// Packs the command byte stream into 64-bit packets, queues them, and hands them one at a time to the SPI master.
// Define SPI_FEEDER_STATS_EN to add the pkt_count/drop_count statistics outputs.
module spi_packet_feeder #(
    parameter int DEPTH        = 4,
    parameter int GAP_CLKS     = 24,
    parameter int TIMEOUT_CLKS = 4800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [63:0]              spi_tx_data,
    output logic                     spi_tx_valid,
    input  logic                     spi_tx_ready,
    input  logic [63:0]              spi_rx_data,
    input  logic                     spi_rx_valid,
    output logic [63:0]              resp_data,
    output logic                     resp_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     frame_err
`ifdef SPI_FEEDER_STATS_EN
    ,
    output logic [15:0]              pkt_count,
    output logic [15:0]              drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int GW = $clog2(GAP_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [55:0]     asm_q, asm_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [63:0]     tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [63:0]     resp_data_q, resp_data_d;
    logic            resp_valid_q, resp_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [63:0]     mem [DEPTH];

    logic [PW-1:0]   level;
    logic            accept, push, pop, timeout;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        in_ready = !(byte_cnt_q == 3'd7 && level == FULL_LVL);
        accept   = in_valid && in_ready && !flush;
        push     = accept && byte_cnt_q == 3'd7;
        // Flush takes priority over issuing the head entry.
        pop      = state_q == IDLE && level != '0 && spi_tx_ready && !flush;
        timeout  = byte_cnt_q != 3'd0 && !accept && !flush && tmo_q == TMO_LAST;
    end

    // Assembly, timeout and FIFO pointers.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        tmo_d       = tmo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tx_data_d   = tx_data_q;
        frame_err_d = 1'b0;
        if (accept) begin
            asm_d      = {asm_q[47:0], in_data};
            byte_cnt_d = byte_cnt_q + 3'd1;
            tmo_d      = '0;
        end else if (byte_cnt_q == 3'd0) begin
            tmo_d = '0;
        end else if (timeout) begin
            byte_cnt_d  = 3'd0;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            tx_data_d = mem[rd_ptr_q[AW-1:0]];
        end
        if (flush) begin
            byte_cnt_d = 3'd0;
            tmo_d      = '0;
            rd_ptr_d   = wr_ptr_q;
        end
    end

    // Transfer sequencing; the valid pulse is the registered image of ISSUE.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        tx_valid_d   = 1'b0;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        case (state_q)
            IDLE:      if (pop) state_d = ISSUE;
            ISSUE: begin
                tx_valid_d = 1'b1;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: if (!spi_tx_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (spi_rx_valid) begin
                resp_data_d  = spi_rx_data;
                resp_valid_d = 1'b1;
                gap_d        = '0;
                state_d      = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + GW'(1);
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= {asm_q, in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 3'd0;
            asm_q        <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign spi_tx_data  = tx_data_q;
    assign spi_tx_valid = tx_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_valid   = resp_valid_q;
    assign frame_err    = frame_err_q;
    assign fifo_level   = level;
    assign busy         = state_q == WAIT_BUSY || state_q == WAIT_DONE || state_q == GAP;

`ifdef SPI_FEEDER_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    // A flush drops every queued entry plus any partially assembled packet.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q == ISSUE) pkt_cnt_d = pkt_cnt_q + 16'd1;
        if (flush)
            drop_cnt_d = drop_cnt_q + 16'(level) + {15'd0, byte_cnt_q != 3'd0};
        else if (timeout)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spi_packet_feeder.sv
// Scoreboard bench for spi_packet_feeder with a behavioural SPI master model.
module tb_spi_packet_feeder;

    localparam int XFER = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [63:0] spi_tx_data;
    logic        spi_tx_valid;
    logic        spi_tx_ready;
    logic [63:0] spi_rx_data = 64'd0;
    logic        spi_rx_valid = 1'b0;
    logic [63:0] resp_data;
    logic        resp_valid;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        frame_err;
`ifdef SPI_FEEDER_STATS_EN
    logic [15:0] pkt_count, drop_count;
`endif

    spi_packet_feeder #(.DEPTH(4), .GAP_CLKS(24), .TIMEOUT_CLKS(4800)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
        .spi_tx_ready(spi_tx_ready), .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .resp_data(resp_data), .resp_valid(resp_valid), .fifo_level(fifo_level),
        .busy(busy), .frame_err(frame_err)
`ifdef SPI_FEEDER_STATS_EN
        , .pkt_count(pkt_count), .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_tx_q[$];
    logic [63:0] exp_resp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Master model: accepts on valid&&ready, drops ready, answers after XFER clocks.
    logic        m_ready = 1'b1, m_hold = 1'b0, m_const = 1'b0, m_noexp = 1'b0;
    logic        m_busy = 1'b0, m_pend = 1'b0;
    logic [63:0] m_data = 64'd0;
    int          m_cnt = 0;
    int          last_rx_cyc = -1000;
    assign spi_tx_ready = m_ready && !m_hold;

    always @(negedge clk) begin
        spi_rx_valid = 1'b0;
        if (m_pend) begin
            m_pend  = 1'b0;
            m_ready = 1'b0;
            m_busy  = 1'b1;
            m_cnt   = XFER;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy       = 1'b0;
                spi_rx_valid = 1'b1;
                spi_rx_data  = m_const ? {8{8'hA5}} : ~m_data;
                if (!m_noexp) exp_resp_q.push_back(spi_rx_data);
                last_rx_cyc  = cyc;
                m_ready      = 1'b1;
            end else begin
                m_cnt--;
            end
        end else if (spi_tx_valid && spi_tx_ready) begin
            m_pend = 1'b1;
            m_data = spi_tx_data;
            if (exp_tx_q.size() == 0) chk("tx_unexpected", spi_tx_data, 64'd0);
            else chk("tx_data", spi_tx_data, exp_tx_q.pop_front());
            $display("tx   %h at cycle %0d", spi_tx_data, cyc);
        end
    end

    // Output monitor: pulse widths, gap, responses, frame errors.
    int   tx_rise_cnt = 0, fe_cnt = 0, tx_run = 0, rs_run = 0;
    logic tx_prev = 1'b0, rs_prev = 1'b0;
    always @(negedge clk) begin
        if (spi_tx_valid && !tx_prev) begin
            tx_rise_cnt++;
            chk("busy_with_valid", 64'(busy), 64'd1);
            chk("gap_ok", 64'((cyc - last_rx_cyc) >= 24), 64'd1);
        end
        if (spi_tx_valid) tx_run++;
        else if (tx_prev) begin
            chk("tx_valid_width", 64'(tx_run), 64'd1);
            tx_run = 0;
        end
        if (resp_valid) begin
            rs_run++;
            if (exp_resp_q.size() == 0) chk("resp_unexpected", resp_data, 64'd0);
            else chk("resp_data", resp_data, exp_resp_q.pop_front());
            $display("resp %h at cycle %0d", resp_data, cyc);
        end else if (rs_prev) begin
            chk("resp_valid_width", 64'(rs_run), 64'd1);
            rs_run = 0;
        end
        if (frame_err) fe_cnt++;
        tx_prev = spi_tx_valid;
        rs_prev = resp_valid;
    end

    task automatic send_byte(input logic [7:0] b, output logic stalled);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        stalled  = !in_ready;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_bound", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] p, input int nb, output int stalls);
        logic s;
        stalls = 0;
        for (int i = 0; i < nb; i++) begin
            send_byte(p[63-8*i -: 8], s);
            if (s) stalls++;
        end
        if (nb == 8) exp_tx_q.push_back(p);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || m_busy || m_pend || fifo_level != 3'd0 || exp_tx_q.size() != 0 ||
                exp_resp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_bound", 64'd0, 64'd1);
    endtask

    task automatic wait_master_busy();
        int n;
        n = 0;
        while (!m_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!m_busy) chk("master_busy_bound", 64'd0, 64'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_tx_valid", 64'(spi_tx_valid), 64'd0);
        chk("rst_tx_data", spi_tx_data, 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
`ifdef SPI_FEEDER_STATS_EN
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    endtask

    initial begin
        int          st, k, tx_before;
        logic [63:0] p;
        logic [63:0] pk[5];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        // 1: single packet, latency and constant response
        m_const = 1'b1;
        send_pkt(64'h0102030405060708, 8, st);
        chk("t1_stalls", 64'(st), 64'd0);
        @(negedge clk); chk("t1_valid_e0", 64'(spi_tx_valid), 64'd0);
        @(negedge clk); chk("t1_valid_e1", 64'(spi_tx_valid), 64'd0);
        @(negedge clk); chk("t1_valid_e2", 64'(spi_tx_valid), 64'd1);
        wait_idle();
        m_const = 1'b0;

        // 2: five packets against a stalled master
        m_hold = 1'b1;
        k = 0;
        for (int i = 0; i < 5; i++) pk[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            send_pkt(pk[i], 8, st);
            k += st;
        end
        send_pkt(pk[4], 7, st);
        k += st;
        chk("t2_stalls_39", 64'(k), 64'd0);
        @(negedge clk);
        in_data  = pk[4][7:0];
        in_valid = 1'b1;
        chk("t2_in_ready_40", 64'(in_ready), 64'd0);
        chk("t2_level_full", 64'(fifo_level), 64'd4);
        m_hold = 1'b0;
        k = 0;
        while (!in_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("t2_byte40_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_tx_q.push_back(pk[4]);
        wait_idle();

        // 3: partial packet timeout then a clean packet
        send_pkt(64'hDEADBE0000000000, 3, st);
        k = 0;
        while (!frame_err && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("t3_timeout_window", 64'(k >= 4795 && k <= 4805), 64'd1);
        @(negedge clk);
        chk("t3_frame_err_pulse", 64'(frame_err), 64'd0);
        send_pkt(64'h1122334455667788, 8, st);
        wait_idle();
        chk("t3_frame_err_count", 64'(fe_cnt), 64'd1);
`ifdef SPI_FEEDER_STATS_EN
        chk("t3_drop_count", 64'(drop_count), 64'd1);
`endif

        // 4: flush during WAIT_DONE of the first of three packets
        m_hold = 1'b1;
        for (int i = 0; i < 3; i++) send_pkt({$urandom, $urandom}, 8, st);
        m_hold = 1'b0;
        wait_master_busy();
        repeat (5) @(negedge clk);
        chk("t4_level_pre", 64'(fifo_level), 64'd2);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_tx_q.delete();
        @(negedge clk);
        chk("t4_level_post", 64'(fifo_level), 64'd0);
        chk("t4_busy_kept", 64'(busy), 64'd1);
        wait_idle();
        tx_before = tx_rise_cnt;
        repeat (200) @(negedge clk);
        chk("t4_no_more_tx", 64'(tx_rise_cnt), 64'(tx_before));
`ifdef SPI_FEEDER_STATS_EN
        chk("t4_drop_count", 64'(drop_count), 64'd3);
        chk("t4_pkt_count", 64'(pkt_count), 64'(tx_rise_cnt));
`endif

        // 6: simultaneous eighth-byte push and IDLE pop with one entry queued
        m_hold = 1'b1;
        send_pkt({$urandom, $urandom}, 8, st);
        p = {$urandom, $urandom};
        send_pkt(p, 7, st);
        @(negedge clk);
        chk("t6_level_pre", 64'(fifo_level), 64'd1);
        in_data  = p[7:0];
        in_valid = 1'b1;
        m_hold   = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_tx_q.push_back(p);
        @(negedge clk);
        chk("t6_level_post", 64'(fifo_level), 64'd1);
        wait_idle();

        // 5: reset mid-WAIT_DONE while the master stays busy
        m_noexp = 1'b1;
        send_pkt({$urandom, $urandom}, 8, st);
        wait_master_busy();
        repeat (5) @(negedge clk);
        m_hold = 1'b1;
        rst    = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        tx_before = tx_rise_cnt;
        repeat (200) @(negedge clk);
        chk("t5_no_tx_held", 64'(tx_rise_cnt), 64'(tx_before));
        m_hold  = 1'b0;
        m_noexp = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5_no_tx_empty", 64'(tx_rise_cnt), 64'(tx_before));
        send_pkt(64'hCAFEF00D12345678, 8, st);
        wait_idle();
        chk("t5_tx_after", 64'(tx_rise_cnt), 64'(tx_before + 1));

        chk("end_tx_queue", 64'(exp_tx_q.size()), 64'd0);
        chk("end_resp_queue", 64'(exp_resp_q.size()), 64'd0);
        chk("end_frame_err_count", 64'(fe_cnt), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
